// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch/pre-decode stage: normalised opcodes,
// fetch state encoding and the registered instruction field bundle.
package cpu_isa_pkg;

   localparam logic [5:0] OP_ADD     = 6'b000000;
   localparam logic [5:0] OP_MUL     = 6'b000100;
   localparam logic [5:0] OP_MOV     = 6'b001000;
   localparam logic [5:0] OP_NOP     = 6'b011100;
   localparam logic [5:0] OP_LD_IMM  = 6'b100000;
   localparam logic [5:0] OP_CMP_IMM = 6'b100011;
   localparam logic [5:0] OP_DEC     = 6'b100100;
   localparam logic [5:0] OP_INPUT   = 6'b100110;
   localparam logic [5:0] OP_OUTPUT  = 6'b100111;
   localparam logic [5:0] OP_BRA     = 6'b101010;
   localparam logic [5:0] OP_BHI     = 6'b101100;
   localparam logic [5:0] OP_BEQ     = 6'b101101;

   typedef enum logic [1:0] {
      S_FETCH       = 2'd0,
      S_OPERAND     = 2'd1,
      S_BRANCH_WAIT = 2'd2,
      S_ISSUE       = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [5:0] opcode;
      logic [1:0] reg_a;
      logic [1:0] reg_b;
      logic [7:0] imm;
   } instr_fields_t;

   // Opcodes whose second byte is an immediate or a branch target.
   function automatic logic is_two_byte_op(input logic [5:0] op);
      return (op == OP_LD_IMM) || (op == OP_CMP_IMM) || (op == OP_BRA) ||
             (op == OP_BHI) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/instr_predecode.sv
// Combinational pre-decode of one program byte into normalised opcode,
// register fields and instruction-class flags.
module instr_predecode
   import cpu_isa_pkg::*;
(
   input  logic [7:0] instr_byte,
   output logic [5:0] opcode,
   output logic [1:0] reg_a,
   output logic [1:0] reg_b,
   output logic       is_two_byte,
   output logic       is_branch,
   output logic       is_cond_branch
);

   always_comb begin
      opcode = '0;
      reg_a  = '0;
      reg_b  = '0;
      if (instr_byte[7]) begin
         opcode = instr_byte[7:2];
         reg_a  = instr_byte[1:0];
      end else begin
         opcode = {instr_byte[7:4], 2'b00};
         reg_a  = instr_byte[3:2];
         reg_b  = instr_byte[1:0];
      end
   end

   assign is_two_byte    = is_two_byte_op(opcode);
   assign is_cond_branch = (opcode == OP_BEQ) || (opcode == OP_BHI);
   assign is_branch      = is_cond_branch || (opcode == OP_BRA);

endmodule

// File: rtl/instruction_fetch.sv
// PC and fetch/pre-decode stage in front of program_memory; resolves branches
// locally and issues all other instructions. NOP_SKIP_EN drops NOPs in fetch.
module instruction_fetch
   import cpu_isa_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              program_clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] address_bus,
   input  logic [7:0]        data_bus,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [5:0]        opcode,
   output logic [1:0]        reg_a,
   output logic [1:0]        reg_b,
   output logic [7:0]        imm,
   input  logic              exec_busy,
   input  logic              flag_z,
   input  logic              flag_c
);

   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] target_q, target_d;
   instr_fields_t     fields_q, fields_d;
   logic              valid_q, valid_d;
   logic              branch_q, branch_d;
   logic              cond_q, cond_d;

   logic [5:0] dec_opcode;
   logic [1:0] dec_reg_a;
   logic [1:0] dec_reg_b;
   logic       dec_is_two_byte;
   logic       dec_is_branch;
   logic       dec_is_cond_branch;
   logic       branch_taken;

   instr_predecode u_predecode (
      .instr_byte     (data_bus),
      .opcode         (dec_opcode),
      .reg_a          (dec_reg_a),
      .reg_b          (dec_reg_b),
      .is_two_byte    (dec_is_two_byte),
      .is_branch      (dec_is_branch),
      .is_cond_branch (dec_is_cond_branch)
   );

   // opcode_q still holds the branch kind while waiting for final flags.
   assign branch_taken = (fields_q.opcode == OP_BEQ) ? flag_z : (!flag_c && !flag_z);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      target_d = target_q;
      fields_d = fields_q;
      valid_d  = 1'b0;
      branch_d = branch_q;
      cond_d   = cond_q;
      case (state_q)
         S_FETCH: begin
            pc_d            = pc_q + PC_INC;
            fields_d.opcode = dec_opcode;
            fields_d.reg_a  = dec_reg_a;
            fields_d.reg_b  = dec_reg_b;
            fields_d.imm    = '0;
            branch_d        = dec_is_branch;
            cond_d          = dec_is_cond_branch;
            if (dec_is_two_byte) begin
               state_d = S_OPERAND;
            end else begin
               state_d = S_ISSUE;
               valid_d = 1'b1;
            end
`ifdef NOP_SKIP_EN
            if (dec_opcode == OP_NOP) begin
               state_d  = S_FETCH;
               valid_d  = 1'b0;
               fields_d = fields_q;
            end
`endif
         end
         S_OPERAND: begin
            pc_d = pc_q + PC_INC;
            if (!branch_q) begin
               fields_d.imm = data_bus;
               state_d      = S_ISSUE;
               valid_d      = 1'b1;
            end else if (!cond_q) begin
               pc_d    = ADDR_W'(data_bus);
               state_d = S_FETCH;
            end else begin
               target_d = ADDR_W'(data_bus);
               state_d  = S_BRANCH_WAIT;
            end
         end
         S_BRANCH_WAIT: begin
            if (!exec_busy) begin
               if (branch_taken) pc_d = target_q;
               state_d = S_FETCH;
            end
         end
         S_ISSUE: begin
            valid_d = 1'b1;
            if (instr_ready) begin
               valid_d = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge program_clk) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         target_q <= '0;
         fields_q <= '0;
         valid_q  <= 1'b0;
         branch_q <= 1'b0;
         cond_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         fields_q <= fields_d;
         valid_q  <= valid_d;
         branch_q <= branch_d;
         cond_q   <= cond_d;
      end
   end

   assign address_bus = pc_q;
   assign instr_valid = valid_q;
   assign opcode      = fields_q.opcode;
   assign reg_a       = fields_q.reg_a;
   assign reg_b       = fields_q.reg_b;
   assign imm         = fields_q.imm;

endmodule
